// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, default line parameters,
// and the oversample-tick divider calculation used by rx and baud_gen.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    localparam int DEF_CLK_HZ = 50_000_000;
    localparam int DEF_BAUD   = 115200;
    localparam int DEF_OSR    = 16;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int calc_div(input int clk_hz, input int baud, input int osr);
        int den;
        den = baud * osr;
        return (clk_hz + den / 2) / den;
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Purpose: 2-FF synchroniser for the async serial line plus registered falling-edge pulse.
// Latency: 2 clocks to synchronise, 1 more clock to flag the edge; line output aligned with fall.
// Backpressure: none, free-running.
module rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic rxd_line,
    output logic rxd_fall
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic dly_q, dly_d;
    logic fall_q, fall_d;

    always_comb begin
        sync1_d = rxd;
        sync2_d = sync1_q;
        dly_d   = sync2_q;
        fall_d  = dly_q & ~sync2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            dly_q   <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            dly_q   <= dly_d;
            fall_q  <= fall_d;
        end
    end

    assign rxd_line = dly_q;
    assign rxd_fall = fall_q;

endmodule

// File: rtl/rx.sv
// Purpose: 8N1 UART receiver, OSR-times oversampled, tick phase restarted on each start edge.
// Latency: byte presented on the clock edge after the stop-bit mid-point sample.
// Backpressure: dout_vld held until dout_ack; a byte completing while unacked is dropped with overrun.
module rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = DEF_CLK_HZ,
    parameter int BAUD   = DEF_BAUD,
    parameter int OSR    = DEF_OSR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] dout,
    output logic       dout_vld,
    input  logic       dout_ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    localparam int DIV = calc_div(CLK_HZ, BAUD, OSR);

    logic rxd_line, rxd_fall;

    rx_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .rxd_line (rxd_line),
        .rxd_fall (rxd_fall)
    );

    rx_state_t   state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  dout_q, dout_d;
    logic        vld_q, vld_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;
    logic        tick;
    logic        deliver;

    always_comb begin
        state_d = state_q;
        tick    = (div_q == 16'(DIV - 1));
        div_d   = tick ? 16'd0 : div_q + 16'd1;
        tcnt_d  = tcnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        vld_d   = vld_q & ~dout_ack;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        deliver = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rxd_fall) begin
                    state_d = ST_START;
                    div_d   = 16'd0;
                    tcnt_d  = 8'd0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (tcnt_q == 8'(OSR / 2 - 1)) begin
                        tcnt_d  = 8'd0;
                        bit_d   = 3'd0;
                        // A line already high at mid-start was a glitch.
                        state_d = rxd_line ? ST_IDLE : ST_DATA;
                    end else begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (tcnt_q == 8'(OSR - 1)) begin
                        tcnt_d  = 8'd0;
                        shift_d = {rxd_line, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (tcnt_q == 8'(OSR - 1)) begin
                        tcnt_d = 8'd0;
                        if (rxd_line) begin
                            deliver = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                end
            end
            ST_BREAK: begin
                if (rxd_line) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // An ack in the delivery cycle frees the slot for the new byte.
        if (deliver) begin
            if (!vld_q || dout_ack) begin
                dout_d = shift_q;
                vld_d  = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            div_q   <= 16'd0;
            tcnt_q  <= 8'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            dout_q  <= 8'h00;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tcnt_q  <= tcnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout      = dout_q;
    assign dout_vld  = vld_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign rx_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rx.sv
// Directed bench for rx at default parameters: 432 clocks per bit, byte delivered
// 3 + 1 + 152*27 = 4108 clocks after the line falls.
module tb_rx;

    localparam int BIT = 432;
    localparam int LAT = 4108;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       rxd      = 1'b1;
    logic       dout_ack = 1'b0;
    logic [7:0] dout;
    logic       dout_vld;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    rx dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .dout_ack  (dout_ack),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
    );

    always #10 clk = ~clk;

    int   n_pass = 0;
    int   n_total = 0;
    int   ferr_cnt = 0;
    int   ovr_cnt = 0;
    int   rise_cnt = 0;
    logic vld_prev = 1'b0;

    always @(negedge clk) begin
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (dout_vld && !vld_prev) rise_cnt++;
        vld_prev = dout_vld;
    end

    typedef struct {
        logic [7:0] data;
        int         bc;
        logic       stopv;
        logic       exp_vld;
        logic [7:0] exp_dout;
        int         exp_ferr;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] got[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Must be called at a negedge; leaves the line at the stop value.
    task automatic send_frame(input logic [7:0] data, input int bc, input logic stopv);
        rxd = 1'b0;
        repeat (bc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            repeat (bc) @(negedge clk);
        end
        rxd = stopv;
        repeat (bc) @(negedge clk);
    endtask

    task automatic wait_vld(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (dout_vld) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic ack_pulse();
        dout_ack = 1'b1;
        @(negedge clk);
        dout_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int f0, o0, r0, lat;
        bit ok0, ok1;

        vecs[0] = '{8'hA5, BIT, 1'b0, 1'b0, 8'h00, 1};
        vecs[1] = '{8'h3C, BIT, 1'b1, 1'b1, 8'h3C, 0};
        vecs[2] = '{8'h00, 421, 1'b1, 1'b1, 8'h00, 0};
        vecs[3] = '{8'hFF, 421, 1'b1, 1'b1, 8'hFF, 0};
        vecs[4] = '{8'h00, 443, 1'b1, 1'b1, 8'h00, 0};
        vecs[5] = '{8'hFF, 443, 1'b1, 1'b1, 8'hFF, 0};

        repeat (3) @(negedge clk);
        check("reset dout", 32'(dout), 32'h00);
        check("reset dout_vld", 32'(dout_vld), 32'h0);
        check("reset frame_err", 32'(frame_err), 32'h0);
        check("reset overrun", 32'(overrun), 32'h0);
        check("reset rx_busy", 32'(rx_busy), 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Back-to-back 75, 01 with ack a few clocks after each delivery.
        f0 = ferr_cnt; o0 = ovr_cnt; r0 = rise_cnt;
        ok0 = 1'b0; ok1 = 1'b0;
        fork
            begin
                send_frame(8'h75, BIT, 1'b1);
                send_frame(8'h01, BIT, 1'b1);
            end
            begin
                wait_vld(ok0);
                got[0] = dout;
                repeat (3) @(negedge clk);
                dout_ack = 1'b1;
                @(negedge clk);
                dout_ack = 1'b0;
                wait_vld(ok1);
                got[1] = dout;
                repeat (3) @(negedge clk);
                dout_ack = 1'b1;
                @(negedge clk);
                dout_ack = 1'b0;
            end
        join
        repeat (5) @(negedge clk);
        check("b2b first seen", 32'(ok0), 32'h1);
        check("b2b second seen", 32'(ok1), 32'h1);
        check("b2b byte0", 32'(got[0]), 32'h75);
        check("b2b byte1", 32'(got[1]), 32'h01);
        check("b2b vld rises", 32'(rise_cnt - r0), 32'd2);
        check("b2b frame_err", 32'(ferr_cnt - f0), 32'd0);
        check("b2b overrun", 32'(ovr_cnt - o0), 32'd0);
        check("b2b vld cleared", 32'(dout_vld), 32'h0);

        // Short low glitch on the line.
        r0 = rise_cnt; f0 = ferr_cnt;
        rxd = 1'b0;
        repeat (50) @(negedge clk);
        check("glitch busy", 32'(rx_busy), 32'h1);
        repeat (50) @(negedge clk);
        rxd = 1'b1;
        repeat (300) @(negedge clk);
        check("glitch idle", 32'(rx_busy), 32'h0);
        check("glitch no byte", 32'(rise_cnt - r0), 32'd0);
        check("glitch no ferr", 32'(ferr_cnt - f0), 32'd0);

        // Single frames: framing error, recovery, and +/-2.5% baud offsets.
        for (int i = 0; i < 6; i++) begin
            f0 = ferr_cnt; o0 = ovr_cnt; r0 = rise_cnt;
            send_frame(vecs[i].data, vecs[i].bc, vecs[i].stopv);
            if (!vecs[i].stopv) begin
                repeat (100) @(negedge clk);
                check($sformatf("v%0d break busy", i), 32'(rx_busy), 32'h1);
                rxd = 1'b1;
                repeat (10) @(negedge clk);
                check($sformatf("v%0d break exit", i), 32'(rx_busy), 32'h0);
            end else begin
                repeat (5) @(negedge clk);
            end
            check($sformatf("v%0d vld", i), 32'(dout_vld), 32'(vecs[i].exp_vld));
            if (vecs[i].exp_vld)
                check($sformatf("v%0d dout", i), 32'(dout), 32'(vecs[i].exp_dout));
            check($sformatf("v%0d frame_err", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("v%0d overrun", i), 32'(ovr_cnt - o0), 32'd0);
            if (dout_vld) begin
                ack_pulse();
                check($sformatf("v%0d ack clears", i), 32'(dout_vld), 32'h0);
            end
        end

        // Two frames never acked: second byte dropped with overrun.
        o0 = ovr_cnt; r0 = rise_cnt;
        send_frame(8'h11, BIT, 1'b1);
        send_frame(8'h22, BIT, 1'b1);
        repeat (5) @(negedge clk);
        check("ovr dout kept", 32'(dout), 32'h11);
        check("ovr vld held", 32'(dout_vld), 32'h1);
        check("ovr pulse", 32'(ovr_cnt - o0), 32'd1);
        check("ovr rises", 32'(rise_cnt - r0), 32'd1);
        ack_pulse();

        // Same pair, ack landing exactly on the second delivery edge.
        o0 = ovr_cnt; r0 = rise_cnt;
        lat = 0;
        fork
            send_frame(8'h11, BIT, 1'b1);
            begin
                while (!dout_vld && lat < 6000) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check("delivery latency", 32'(lat), 32'(LAT));
        fork
            send_frame(8'h22, BIT, 1'b1);
            begin
                repeat (LAT - 1) @(negedge clk);
                dout_ack = 1'b1;
                @(negedge clk);
                dout_ack = 1'b0;
            end
        join
        repeat (5) @(negedge clk);
        check("ack-edge dout", 32'(dout), 32'h22);
        check("ack-edge vld", 32'(dout_vld), 32'h1);
        check("ack-edge overrun", 32'(ovr_cnt - o0), 32'd0);
        check("ack-edge rises", 32'(rise_cnt - r0), 32'd1);

        // Reset during bit 4 of FF, with byte 22 still pending.
        fork
            send_frame(8'hFF, BIT, 1'b1);
            begin
                repeat (5 * BIT + 200) @(negedge clk);
                check("pre-rst busy", 32'(rx_busy), 32'h1);
                rst = 1'b1;
                #1;
                check("rst dout", 32'(dout), 32'h00);
                check("rst vld", 32'(dout_vld), 32'h0);
                check("rst busy", 32'(rx_busy), 32'h0);
                @(negedge clk);
                rst = 1'b0;
                r0 = rise_cnt; f0 = ferr_cnt;
            end
        join
        repeat (5) @(negedge clk);
        check("post-rst no byte", 32'(rise_cnt - r0), 32'd0);
        check("post-rst no ferr", 32'(ferr_cnt - f0), 32'd0);
        send_frame(8'h5A, BIT, 1'b1);
        repeat (5) @(negedge clk);
        check("post-rst vld", 32'(dout_vld), 32'h1);
        check("post-rst dout", 32'(dout), 32'h5A);
        ack_pulse();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
